mod_reduce: RTL

//  Sequential modular reducer downstream of the shift-add multiplier: takes the
//  2W-bit unsigned product and returns product mod N (W-bit) for the Paillier

---
 rtl/mod_reduce.sv | 79 +++++++
 1 files changed

// File: rtl/mod_reduce.sv
// mod_reduce: bit-serial restoring reducer, dividend mod modulus, one dividend bit per clock.
// Define MOD_REDUCE_QUOTIENT_EN to add the red_quotient output.
module mod_reduce #(
   parameter int W  = 4096,
   parameter int PW = 2*W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          red_begin,
   input  logic [PW-1:0] red_dividend,
   input  logic [W-1:0]  red_modulus,
   output logic [W-1:0]  red_remainder,
   output logic          red_end,
   output logic          red_busy,
`ifdef MOD_REDUCE_QUOTIENT_EN
   output logic [PW-1:0] red_quotient,
`endif
   output logic          red_err
);
   localparam int CW = $clog2(PW);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [PW-1:0] d;
   logic [W-1:0] m, r, r_nx;
   logic [CW-1:0] cnt;
   logic [W:0] t;
   logic take;
   // r < m always holds, so t < 2m and the difference fits in W bits
   assign t = {r, d[cnt]};
   assign take = t >= {1'b0, m};
   assign r_nx = take ? W'(t - {1'b0, m}) : t[W-1:0];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = red_begin ? (red_modulus == '0 ? DONE : RUN) : IDLE;
         RUN:     state_nx = !red_begin ? IDLE : (cnt == '0 ? DONE : RUN);
         DONE:    state_nx = red_begin ? DONE : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         d <= '0;
         m <= '0;
         r <= '0;
         cnt <= '0;
         red_remainder <= '0;
         red_end <= 1'b0;
         red_busy <= 1'b0;
         red_err <= 1'b0;
`ifdef MOD_REDUCE_QUOTIENT_EN
         red_quotient <= '0;
`endif
      end else begin
         red_busy <= state_nx == RUN;
         red_end <= state_nx == DONE;
         if (state == IDLE && red_begin) begin
            d <= red_dividend;
            m <= red_modulus;
            r <= '0;
            cnt <= CW'(PW-1);
            red_err <= red_modulus == '0;
            if (red_modulus == '0) red_remainder <= '0;
`ifdef MOD_REDUCE_QUOTIENT_EN
            red_quotient <= '0;
`endif
         end else if (state == RUN && red_begin) begin
            r <= r_nx;
            cnt <= cnt - 1'b1;
            if (cnt == '0) red_remainder <= r_nx;
`ifdef MOD_REDUCE_QUOTIENT_EN
            red_quotient <= {red_quotient[PW-2:0], take};
`endif
         end
      end
endmodule
